// File: rtl/input_unit_fsm_pkg.sv
// Router types shared by the input unit: flit layout, port indices, FSM states, XY routing.
package input_unit_fsm_pkg;

  localparam int COORD_W      = 4;
  localparam int PAYLOAD_W    = 16;
  localparam int NUM_OF_PORTS = 5;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } FLIT_TYPE_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTING = 2'd1,
    WAITING = 2'd2,
    ACTIVE  = 2'd3
  } GLOBAL_STATE_t;

  typedef struct packed {
    logic       valid;
    FLIT_TYPE_t flit_type;
  } FLIT_TAIL_t;

  // dst_x/dst_y are meaningful on head flits only
  typedef struct packed {
    FLIT_TAIL_t           tail;
    logic [COORD_W-1:0]   dst_x;
    logic [COORD_W-1:0]   dst_y;
    logic [PAYLOAD_W-1:0] payload;
  } FLIT_t;

  typedef logic [NUM_OF_PORTS-1:0] PORT_VEC_t;

  function automatic PORT_VEC_t xy_route(input logic [COORD_W-1:0] dst_x,
                                         input logic [COORD_W-1:0] dst_y,
                                         input logic [COORD_W-1:0] local_x,
                                         input logic [COORD_W-1:0] local_y);
    PORT_VEC_t r;
    r = '0;
    if (dst_x > local_x)      r[EAST]  = 1'b1;
    else if (dst_x < local_x) r[WEST]  = 1'b1;
    else if (dst_y > local_y) r[NORTH] = 1'b1;
    else if (dst_y < local_y) r[SOUTH] = 1'b1;
    else                      r[LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/input_unit_fsm_if.sv
// Link/switch signal bundle of one router input port; slave = input unit, master = its environment.
interface input_unit_fsm_if;
  import input_unit_fsm_pkg::*;

  logic          i_upstream_req;
  logic          o_upstream_ack;
  FLIT_t         i_flit;
  PORT_VEC_t     o_switch_req;
  PORT_VEC_t     i_outport_ack;
  FLIT_t         o_flit;
  GLOBAL_STATE_t o_gstate;
  logic          o_overflow;

  modport slave (
    input  i_upstream_req, i_flit, i_outport_ack,
    output o_upstream_ack, o_switch_req, o_flit, o_gstate, o_overflow
  );

  modport master (
    output i_upstream_req, i_flit, i_outport_ack,
    input  o_upstream_ack, o_switch_req, o_flit, o_gstate, o_overflow
  );
endinterface

// File: rtl/input_unit_fsm_flit_fifo.sv
// Synchronous flit FIFO with fall-through read data; push while full is taken only with a same-cycle pop.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module flit_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdat    = r_mem[r_rptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdat;
  end
endmodule

// File: rtl/input_unit_fsm.sv
// Router input unit: acks upstream, buffers flits, XY-routes the head, streams the packet to the crossbar.
// Head latency 3 cycles via FIFO, 1 flit/cycle; `INPUT_UNIT_BYPASS_EN adds a same-cycle path when ACTIVE and empty.
module input_unit_fsm
  import input_unit_fsm_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned LOCAL_X   = 0,
  parameter int unsigned LOCAL_Y   = 0
) (
  input logic              clk,
  input logic              reset_n,
  input_unit_fsm_if.slave  io_if
);
  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

  GLOBAL_STATE_t r_state, w_state_nxt;
  PORT_VEC_t     r_out_port, w_out_port_nxt;
  logic          r_first, w_first_nxt;
  logic          r_overflow;

  FLIT_t     w_in;
  FLIT_t     w_front;
  FLIT_t     w_flit_out;
  PORT_VEC_t w_switch_req;
  logic      w_ack;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  logic      w_bypass;
  logic      w_drop;

  assign w_in = io_if.i_flit;

`ifdef INPUT_UNIT_BYPASS_EN
  assign w_bypass = (r_state == ACTIVE) && w_empty && w_in.tail.valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_in.tail.valid && !w_bypass;
  assign w_drop = w_push && w_full && !w_pop;

  flit_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(FLIT_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdat  (w_in),
    .i_pop   (w_pop),
    .o_rdat  (w_front),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_out_port_nxt = r_out_port;
    w_first_nxt    = r_first;
    w_pop          = 1'b0;
    w_ack          = 1'b0;
    w_switch_req   = '0;
    w_flit_out     = '0;
    case (r_state)
      IDLE: begin
        w_ack       = io_if.i_upstream_req && w_empty;
        w_first_nxt = 1'b1;
        if (w_ack) w_state_nxt = ROUTING;
      end
      ROUTING: begin
        // A tail-typed first flit is a single-flit packet and carries the route
        if (!w_empty) begin
          if (w_front.tail.flit_type == HEAD_FLIT ||
              (r_first && w_front.tail.flit_type == TAIL_FLIT)) begin
            w_out_port_nxt = xy_route(w_front.dst_x, w_front.dst_y, LX, LY);
            w_state_nxt    = WAITING;
          end else begin
            w_pop       = 1'b1;
            w_first_nxt = 1'b0;
          end
        end
      end
      WAITING: begin
        w_switch_req = r_out_port;
        if (|(io_if.i_outport_ack & r_out_port)) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        w_switch_req = r_out_port;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_flit_out = w_front;
        end else if (w_bypass) begin
          w_flit_out = w_in;
        end
        if (w_flit_out.tail.valid && w_flit_out.tail.flit_type == TAIL_FLIT)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_out_port <= '0;
      r_first    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_out_port <= w_out_port_nxt;
      r_first    <= w_first_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign io_if.o_upstream_ack = w_ack;
  assign io_if.o_switch_req   = w_switch_req;
  assign io_if.o_flit         = w_flit_out;
  assign io_if.o_gstate       = r_state;
  assign io_if.o_overflow     = r_overflow;
endmodule

// File: tb/tb_input_unit_fsm.sv
module tb_input_unit_fsm;
  import input_unit_fsm_pkg::*;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  input_unit_fsm_if u ();
  input_unit_fsm_if v ();

  input_unit_fsm #(.BUF_DEPTH(8), .LOCAL_X(1), .LOCAL_Y(1)) dut (
    .clk(clk), .reset_n(reset_n), .io_if(u)
  );
  input_unit_fsm #(.BUF_DEPTH(2), .LOCAL_X(1), .LOCAL_Y(1)) dut_small (
    .clk(clk), .reset_n(reset_n), .io_if(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic FLIT_t mk(input FLIT_TYPE_t t, input int x, input int y, input int p);
    FLIT_t f;
    f.tail.valid     = 1'b1;
    f.tail.flit_type = t;
    f.dst_x          = 4'(x);
    f.dst_y          = 4'(y);
    f.payload        = 16'(p);
    return f;
  endfunction

  // Expected output port for a router sitting at (1,1): X first, then Y
  function automatic logic [4:0] ref_port(input int x, input int y);
    int idx;
    if (x > 1)      idx = 2;
    else if (x < 1) idx = 4;
    else if (y > 1) idx = 1;
    else if (y < 1) idx = 3;
    else            idx = 0;
    return 5'(1 << idx);
  endfunction

  task automatic send_packet(input int dx, input int dy, input int len, input int ack_dly, input bit gaps);
    FLIT_t      fl[$];
    FLIT_t      exp_q[$];
    logic [4:0] ep;
    int         sent, cyc, wcnt;
    bit         done, exp_idle, exp_head, p_idle, p_head;
    ep = ref_port(dx, dy);
    for (int i = 0; i < len; i++) begin
      FLIT_TYPE_t t;
      t = (i == len - 1) ? TAIL_FLIT : ((i == 0) ? HEAD_FLIT : BODY_FLIT);
      if (i == 0) fl.push_back(mk(t, dx, dy, int'($urandom_range(0, 65535))));
      else        fl.push_back(mk(t, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                  int'($urandom_range(0, 65535))));
    end
    exp_q = fl;
    @(negedge clk);
    u.i_upstream_req = 1'b1;
    u.i_flit         = '0;
    u.i_outport_ack  = '0;
    #1;
    chk("idle_before_req", u.o_gstate, IDLE);
    chk("ack_same_cycle", u.o_upstream_ack, 1);
    sent = 0; cyc = 1; wcnt = -1;
    done = 0; exp_idle = 0; exp_head = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      p_idle = exp_idle;
      p_head = exp_head;
      exp_head = 0;
      u.i_upstream_req = (!p_idle && u.o_gstate != IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (sent < len && (sent == 0 || !gaps || $urandom_range(0, 2) != 0)) begin
        u.i_flit = fl[sent];
        sent++;
      end else begin
        u.i_flit = '0;
      end
      u.i_outport_ack = '0;
      if (u.o_gstate == WAITING) begin
        if (wcnt < 0) wcnt = ack_dly;
        if (wcnt == 0) begin
          u.i_outport_ack = ep | (5'($urandom) & ~ep);
          exp_head = 1;
        end else begin
          u.i_outport_ack = 5'($urandom) & ~ep;
        end
        wcnt--;
      end
      #1;
      if (cyc <= 2) chk("routing_after_ack", u.o_gstate, ROUTING);
      if (cyc == 3) chk("waiting_at_t3", u.o_gstate, WAITING);
      if (u.o_gstate != IDLE) chk("no_ack_when_busy", u.o_upstream_ack, 0);
      if (u.o_gstate == WAITING || u.o_gstate == ACTIVE) chk("switch_req", u.o_switch_req, ep);
      if (p_head) begin
        chk("active_after_outack", u.o_gstate, ACTIVE);
        chk("head_after_outack", u.o_flit, fl[0]);
      end
      if (p_idle) begin
        chk("idle_after_tail", u.o_gstate, IDLE);
        done = 1;
      end
      chk("no_overflow", u.o_overflow, 0);
      if (u.o_flit.tail.valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_flit", u.o_flit, 0);
        end else begin
          chk("flit_order", u.o_flit, exp_q[0]);
          if (exp_q[0].tail.flit_type == TAIL_FLIT) exp_idle = 1;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("bubble_zero", u.o_flit, 0);
      end
      cyc++;
    end
    chk("packet_completed", done, 1);
    chk("all_flits_out", exp_q.size(), 0);
  endtask

  initial begin
    FLIT_t h, b1, b2, t;
    reset_n = 1'b0;
    u.i_upstream_req = 1'b0; u.i_flit = '0; u.i_outport_ack = '0;
    v.i_upstream_req = 1'b0; v.i_flit = '0; v.i_outport_ack = '0;
    #1;
    chk("rst_state", u.o_gstate, IDLE);
    chk("rst_ack", u.o_upstream_ack, 0);
    chk("rst_switch_req", u.o_switch_req, 0);
    chk("rst_flit", u.o_flit, 0);
    chk("rst_overflow", u.o_overflow, 0);
    chk("rst_small_state", v.o_gstate, IDLE);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed packets from the plan, then randomized traffic
    send_packet(3, 1, 4, 0, 1'b0);
    send_packet(1, 1, 1, 0, 1'b0);
    send_packet(0, 2, 6, 5, 1'b0);
    send_packet(1, 0, 3, 2, 1'b1);
    for (int k = 0; k < 25; k++)
      send_packet(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(1, 8)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));

    // Two-deep FIFO, output ack withheld: third and fourth flits are dropped
    h  = mk(HEAD_FLIT, 3, 1, 16'h1111);
    b1 = mk(BODY_FLIT, 0, 0, 16'h2222);
    b2 = mk(BODY_FLIT, 0, 0, 16'h3333);
    t  = mk(TAIL_FLIT, 0, 0, 16'h4444);
    @(negedge clk); v.i_upstream_req = 1'b1;
    #1 chk("ovf_ack", v.o_upstream_ack, 1);
    @(negedge clk); v.i_upstream_req = 1'b0; v.i_flit = h;
    #1 chk("ovf_clear_c1", v.o_overflow, 0);
    @(negedge clk); v.i_flit = b1;
    #1 chk("ovf_clear_c2", v.o_overflow, 0);
    @(negedge clk); v.i_flit = b2;
    #1 chk("ovf_clear_c3", v.o_overflow, 0);
    chk("ovf_waiting", v.o_gstate, WAITING);
    @(negedge clk); v.i_flit = t;
    #1 chk("ovf_set", v.o_overflow, 1);
    @(negedge clk); v.i_flit = '0; v.i_outport_ack = 5'b00100;
    #1 chk("ovf_sticky", v.o_overflow, 1);
    chk("ovf_switch_req", v.o_switch_req, 5'b00100);
    @(negedge clk); v.i_outport_ack = '0;
    #1 chk("ovf_active", v.o_gstate, ACTIVE);
    chk("ovf_head_out", v.o_flit, h);
    @(negedge clk);
    #1 chk("ovf_body_out", v.o_flit, b1);
    @(negedge clk);
    #1 chk("ovf_lost_bubble", v.o_flit, 0);
    chk("ovf_stuck_active", v.o_gstate, ACTIVE);

    // Reset pulse while a packet is streaming
    @(negedge clk); u.i_upstream_req = 1'b1;
    #1 chk("rstmid_ack", u.o_upstream_ack, 1);
    @(negedge clk); u.i_upstream_req = 1'b0; u.i_flit = mk(HEAD_FLIT, 2, 1, 16'hAAAA);
    @(negedge clk); u.i_flit = mk(BODY_FLIT, 0, 0, 16'hBBBB);
    @(negedge clk); u.i_flit = mk(BODY_FLIT, 0, 0, 16'hCCCC); u.i_outport_ack = 5'b00100;
    #1 chk("rstmid_waiting", u.o_gstate, WAITING);
    @(negedge clk); u.i_flit = mk(BODY_FLIT, 0, 0, 16'hDDDD); u.i_outport_ack = '0;
    #1 chk("rstmid_active", u.o_gstate, ACTIVE);
    chk("rstmid_head", u.o_flit, mk(HEAD_FLIT, 2, 1, 16'hAAAA));
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_state", u.o_gstate, IDLE);
    chk("rstmid_flit", u.o_flit, 0);
    chk("rstmid_switch_req", u.o_switch_req, 0);
    chk("rstmid_overflow", u.o_overflow, 0);
    chk("rstmid_small_overflow", v.o_overflow, 0);
    chk("rstmid_small_state", v.o_gstate, IDLE);
    u.i_flit = '0;
    @(negedge clk); reset_n = 1'b1; u.i_upstream_req = 1'b1;
    #1 chk("ack_after_reset", u.o_upstream_ack, 1);
    @(negedge clk); u.i_upstream_req = 1'b0;
    #1 chk("routing_after_reset", u.o_gstate, ROUTING);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_unit_fsm.md
# input_unit_fsm

Receive-side controller for one router input port, the far end of the link driven by an upstream router's output unit. It grants the upstream link request and buffers the incoming packet's flits in a FIFO. It computes the XY route from the head flit, requests the selected local output unit through the switch, and streams the buffered flits to the crossbar until the tail flit leaves. It handles one packet at a time.

## Interface
Parameters:
- BUF_DEPTH, 8: FIFO depth in flits; power of two, ≥2.
- LOCAL_X, 0: this router's X coordinate.
- LOCAL_Y, 0: this router's Y coordinate.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_upstream_req  input  1  link request from the upstream output unit.
- o_upstream_ack  output  1  link grant to upstream.
- i_flit  input  FLIT_t  incoming flit; `tail.valid` qualifies it.
- o_switch_req  output  NUM_OF_PORTS  one-hot request to the selected output unit.
- i_outport_ack  input  NUM_OF_PORTS  grant from the output units.
- o_flit  output  FLIT_t  flit toward the crossbar; all-zero when not valid.
- o_gstate  output  GLOBAL_STATE_t  current state.
- o_overflow  output  1  sticky flag: a valid flit was dropped because the FIFO was full.

## Operation
States (GLOBAL_STATE_t): IDLE, ROUTING, WAITING, ACTIVE.
- IDLE: `o_upstream_ack = i_upstream_req` (combinational, same cycle); the condition also requires the FIFO to be empty.
  - Transition to ROUTING when ack=1.
- ROUTING: waits until the FIFO is non-empty.
  - Head flit at front (`flit_type==HEAD_FLIT`): compute the route and register one-hot `out_port`, then go to WAITING.
  - Front flit not HEAD: pop and discard it, stay in ROUTING.
- Route (xy_route):
  - dst_x > LOCAL_X → EAST; dst_x < LOCAL_X → WEST.
  - Else dst_y > LOCAL_Y → NORTH; dst_y < LOCAL_Y → SOUTH.
  - Else LOCAL.
- WAITING: `o_switch_req = out_port`. Go to ACTIVE when `(i_outport_ack & out_port) != 0`; acks on other bits are ignored.
- ACTIVE: `o_switch_req = out_port` held.
  - FIFO non-empty: pop one flit per cycle onto `o_flit`.
  - FIFO empty: `o_flit = '0` (bubble).
  - Tail popped (valid, `flit_type==TAIL_FLIT`): go to IDLE next cycle.
- FIFO write: every cycle where `i_flit.tail.valid` is set and the FIFO is not full, in any state.
  - Valid flit while full: flit dropped and `o_overflow` set to 1 until reset.
  - Simultaneous push and pop while full: the push is accepted.
- Single-flit packet (head with tail type): the route is taken from it, and popping it ends ACTIVE.

## Timing
- Reset values: state IDLE, FIFO empty, `out_port=0`, `o_overflow=0`; `o_upstream_ack`, `o_switch_req` and `o_flit` all 0.
- Reset asserted mid-packet: the FIFO and the packet are discarded.
- Ack in cycle T:
  - ROUTING from T+1; the upstream's head flit arrives at T+1.
  - Head is at the FIFO front at T+2; WAITING at T+3, with `o_switch_req` asserted.
- Output ack seen in cycle W: ACTIVE at W+1, and the head flit appears on `o_flit` at W+1.
- Minimum head latency from link in to crossbar out (FIFO path): 3 cycles.
- Throughput: 1 flit/cycle.
- `o_upstream_ack` is never asserted outside IDLE, and never while the FIFO holds data.

## Configuration
- `INPUT_UNIT_BYPASS_EN` defined: in ACTIVE, with the FIFO empty, a valid `i_flit` is driven directly onto `o_flit` in the same cycle and is not written to the FIFO.
  - A tail flit on the bypass path ends ACTIVE.
- Undefined: every flit passes through the FIFO.
  - This gives a minimum 1-cycle ACTIVE latency per flit.

## Structure
- router_pkg additions:
  - Port index localparams LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4 (NUM_OF_PORTS=5).
  - The `xy_route` function.
  - Head-view fields `dst_x` and `dst_y` in FLIT_t.
- Existing router_pkg items reused: FLIT_t, FLIT_TYPE_t, GLOBAL_STATE_t.
- Sub-module `flit_fifo`: parameterised synchronous FIFO.
  - Inputs: push, pop.
  - Outputs: full, empty.
  - Pointers are one bit wider than the address, for wrap-around detection.

## Test plan
- Reset, then req=1 with the FIFO empty → ack=1 in the same cycle; state ROUTING next cycle.
- LOCAL (1,1), head dst (3,1), 4-flit packet → `o_switch_req=5'b00100`; after the ack, H,B,B,T appear on consecutive cycles; IDLE after T.
- Head dst (1,1) single-flit packet (type TAIL_FLIT) → `o_switch_req=5'b00001`; one flit out, then IDLE.
- Output ack delayed 5 cycles with BUF_DEPTH=8 → all 6 flits buffered; `o_overflow=0`; `o_switch_req` stable throughout WAITING.
- BUF_DEPTH=2, 4-flit packet, output ack withheld → `o_overflow=1` once the third flit arrives; flits 3–4 dropped.
- reset_n pulsed low during ACTIVE → state IDLE, `o_flit=0`, `o_overflow=0` immediately; a new request is acked right after reset release.
